rstatus_handler: RTL
====================

// Module: rstatus_handler
// PURPOSE
//  Consumer side of the exception-status path. Takes true_overflow/rstatus_value from the ALU path and setx writes
//  from decode, and holds architectural rstatus ($r30). Drives bex_taken, a req/ack trap handshake to PC-select
//  logic, and a show-ahead FIFO log of overflow codes for debug readout. Sits beside the regfile in the writeback stage.
// PARAMETERS
//  LOG_AW  2  log2 of exception-log depth (depth = 2**LOG_AW = 4)
//  CNT_W   8  width of saturating drop counter
// PORTS
//  clock        in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-high; clears all state
//  ovf_valid    in   1       overflow event this cycle (true_overflow)
//  ovf_value    in   32      rstatus code for event (1 add, 2 addi, 3 sub)
//  setx_valid   in   1       setx instruction commits this cycle
//  setx_target  in   27      setx immediate T; zero-extended to 32
//  rstatus_q    out  32      current rstatus register
//  bex_taken    out  1       rstatus_q != 0 (combinational from register)
//  trap_req     out  1       trap request to PC-select logic
//  trap_ack     in   1       PC-select accepts trap
//  trap_code    out  32      code of trap being requested
//  log_pop      in   1       pop head of exception log
//  log_data     out  32      head of log (valid when !log_empty)
//  log_empty    out  1       log holds 0 entries
//  log_full     out  1       log holds 2**LOG_AW entries
//  drop_count   out  CNT_W   overflow events lost to a full log, saturating
// BEHAVIOUR
//  Reset (async, immediate): rstatus_q=0, trap_req=0, trap_code=0, log empty (log_empty=1, log_full=0),
//   log_data=0, drop_count=0, FSM=IDLE.
//  rstatus write, next rising edge: ovf_valid -> ovf_value; else setx_valid -> {5'b0,setx_target}; else hold.
//   Simultaneous ovf_valid & setx_valid: overflow wins, setx discarded. ovf_value written as given, including 0.
//  bex_taken follows rstatus_q with zero latency; 1 in the cycle after an overflow edge.
//  Trap FSM states IDLE, REQ, HOLD:
//   IDLE: trap_req=0; ovf_valid -> REQ, trap_code<=ovf_value.
//   REQ: trap_req=1, trap_code stable; trap_ack -> HOLD; further ovf_valid does not change trap_code (coalesced).
//   HOLD: trap_req=0 for exactly one cycle -> IDLE; ovf_valid in HOLD does not start a new trap.
//   trap_ack outside REQ ignored. trap_code holds last value after trap.
//  Exception log (FIFO, depth 2**LOG_AW, pointers wrap modulo depth, count LOG_AW+1 bits):
//   Every ovf_valid is a push of ovf_value; setx never logs. Pop = log_pop & !log_empty; pop on empty ignored.
//   log_data = entry at read pointer (show-ahead, no pop latency); 0 when empty.
//   Push & pop same cycle: both occur, count unchanged, including when full.
//   Push when full without pop: entry dropped, drop_count+1, saturates at 2**CNT_W-1.
//   Push when empty with pop: push only (pop ignored); log_data shows value next cycle.
//  Reset mid-trap or mid-log: state cleared at once; trap_req drops asynchronously.
// TESTING
//  1 Reset with ovf_valid=1 held -> all outputs 0/empty; first edge after release writes rstatus, trap_req=1.
//  2 ovf_valid, ovf_value=1 -> next cycle rstatus_q=1, bex_taken=1, trap_req=1, trap_code=1, log_data=1.
//    trap_ack 2 cycles later -> trap_req=0 one cycle (HOLD), then IDLE.
//  3 Same cycle: ovf_valid value 3 and setx_valid T=0x155 -> rstatus_q=3.
//    Then setx T=0x7FFFFFF alone -> rstatus_q=0x07FFFFFF; setx T=0 -> bex_taken=0.
//  4 Six consecutive overflows 1,2,3,1,2,3 with no pops -> log_full=1, drop_count=2.
//    Pops return 1,2,3,1 and log_empty=1 after the 4th pop; an extra pop is ignored.
//  5 Log full, push 2 and pop same cycle -> count stays 4, drop_count unchanged, new tail=2.
//  6 In REQ with trap_code=2, overflow value 3 -> trap_code stays 2, rstatus_q=3, log gains 3.
//    Assert reset in REQ -> trap_req=0 before the next edge.

Source files
------------

// File: rtl/rstatus_handler.sv
// rstatus_handler
//   Consumer side of the exception-status path in the writeback stage.
//   Holds architectural rstatus ($r30), raises a req/ack trap handshake
//   toward PC-select, and keeps a small show-ahead FIFO of overflow codes
//   for debug readout, with a saturating count of codes lost to a full log.
//
// Ports
//   clock        rising-edge system clock
//   reset        asynchronous, active-high; clears all state
//   ovf_valid    overflow event this cycle
//   ovf_value    rstatus code for the overflow event
//   setx_valid   setx commits this cycle
//   setx_target  setx immediate, zero-extended to 32 bits
//   rstatus_q    current rstatus register
//   bex_taken    rstatus_q != 0
//   trap_req     trap request to PC-select
//   trap_ack     PC-select accepts the trap
//   trap_code    code of the trap being requested
//   log_pop      pop head of exception log
//   log_data     head of log (0 when empty)
//   log_empty    log holds no entries
//   log_full     log holds 2**LOG_AW entries
//   drop_count   overflow events lost to a full log, saturating
module rstatus_handler #(
  parameter int LOG_AW = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ovf_valid,
  input  logic [31:0]      ovf_value,
  input  logic             setx_valid,
  input  logic [26:0]      setx_target,
  output logic [31:0]      rstatus_q,
  output logic             bex_taken,
  output logic             trap_req,
  input  logic             trap_ack,
  output logic [31:0]      trap_code,
  input  logic             log_pop,
  output logic [31:0]      log_data,
  output logic             log_empty,
  output logic             log_full,
  output logic [CNT_W-1:0] drop_count
);

  localparam int DEPTH = 1 << LOG_AW;
  localparam logic [LOG_AW:0]   FULL_CNT = (LOG_AW+1)'(DEPTH);
  localparam logic [LOG_AW:0]   CNT_ONE  = (LOG_AW+1)'(1);
  localparam logic [LOG_AW-1:0] PTR_ONE  = (LOG_AW)'(1);
  localparam logic [CNT_W-1:0]  DROP_ONE = (CNT_W)'(1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t            state_reg;
  logic [31:0]       mem [DEPTH];
  logic [LOG_AW-1:0] wr_ptr_reg;
  logic [LOG_AW-1:0] rd_ptr_reg;
  logic [LOG_AW:0]   count_reg;

  logic pop;
  logic push;
  logic drop;

  // ---------------------------------------------------------------
  // rstatus register: overflow beats setx when both arrive together
  // ---------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rstatus_q <= '0;
    end else if (ovf_valid) begin
      rstatus_q <= ovf_value;
    end else if (setx_valid) begin
      rstatus_q <= {5'b0, setx_target};
    end
  end

  assign bex_taken = |rstatus_q;

  // ---------------------------------------------------------------
  // Trap handshake. Overflows arriving while a trap is outstanding
  // (REQ) or just retired (HOLD) are coalesced into it: they update
  // rstatus and the log but never the trap code.
  // ---------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      trap_req  <= 1'b0;
      trap_code <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ovf_valid) begin
            state_reg <= REQ;
            trap_req  <= 1'b1;
            trap_code <= ovf_value;
          end
        end
        REQ: begin
          if (trap_ack) begin
            state_reg <= HOLD;
            trap_req  <= 1'b0;
          end
        end
        HOLD: begin
          state_reg <= IDLE;
          trap_req  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          trap_req  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Exception log. A pop frees a slot in the same cycle, so a push
  // into a full log succeeds when paired with a pop.
  // ---------------------------------------------------------------
  assign log_empty = (count_reg == '0);
  assign log_full  = (count_reg == FULL_CNT);
  assign pop       = log_pop & ~log_empty;
  assign push      = ovf_valid & (~log_full | pop);
  assign drop      = ovf_valid & log_full & ~pop;

  // Storage needs no reset: entries are only visible through valid pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= ovf_value;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_ONE;
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_ONE;
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + DROP_ONE;
      end
    end
  end

  // Show-ahead head of log; forced to zero while empty.
  assign log_data = log_empty ? 32'd0 : mem[rd_ptr_reg];

endmodule
